midi_byte_parser: RTL and testbench

MIDI_BYTE_PARSER -- requirements
Module: midi_byte_parser

---
 rtl/midi_byte_parser_if.sv | 50 +++++
 rtl/midi_byte_parser.sv | 215 +++++++++++++++++++++
 tb/tb_midi_byte_parser.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_byte_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : midi_byte_parser_if
// Description : Bundle for the MIDI byte parser. It carries the FWFT receive
//               FIFO read side, the channel-message output channel and the
//               sysex byte output channel.
// Revision    : 1.0  initial release
// ============================================================================
interface midi_byte_parser_if;
  // Receive FIFO read side
  logic [7:0] fifo_out;
  logic       fifo_empty;
  logic       fifo_rd_rst_busy;
  logic       fifo_rd;
  // Channel message channel
  logic       midi_valid;
  logic [3:0] midi_cmd;
  logic [3:0] midi_ch;
  logic [6:0] midi_data1;
  logic [6:0] midi_data2;
  logic       midi_rd;
  logic       midi_busy;
  // Sysex byte channel
  logic       sysex_valid;
  logic [7:0] sysex_data;
  logic       sysex_last;
  logic       sysex_rd;
  logic       sysex_busy;

  // Parser side
  modport master (
    input  fifo_out, fifo_empty, fifo_rd_rst_busy,
    output fifo_rd,
    output midi_valid, midi_cmd, midi_ch, midi_data1, midi_data2,
    input  midi_rd, midi_busy,
    output sysex_valid, sysex_data, sysex_last,
    input  sysex_rd, sysex_busy
  );

  // FIFO and consumer side
  modport slave (
    output fifo_out, fifo_empty, fifo_rd_rst_busy,
    input  fifo_rd,
    input  midi_valid, midi_cmd, midi_ch, midi_data1, midi_data2,
    output midi_rd, midi_busy,
    input  sysex_valid, sysex_data, sysex_last,
    output sysex_rd, sysex_busy
  );
endinterface
`default_nettype wire

// File: rtl/midi_byte_parser.sv
`default_nettype none
// ============================================================================
// Module      : midi_byte_parser
// Description : Pops MIDI bytes from a FWFT FIFO, assembles channel messages
//               (with running status), forwards sysex byte-by-byte and counts
//               discarded bytes in a saturating counter.
// Revision    : 1.0  initial release
// ============================================================================
module midi_byte_parser #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  midi_byte_parser_if.master    bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_D1, S_D2, S_EX, S_EX_END} state_t;

  state_t                state_q, state_d, eff_state;
  logic                  run_q;
  logic                  rs_valid_q, rs_valid_d;
  logic [3:0]            rs_cmd_q, rs_cmd_d, rs_ch_q, rs_ch_d;
  logic [6:0]            d1_q, d1_d;
  logic [7:0]            hold_q, hold_d;
  logic                  midi_valid_q, midi_pend_q;
  logic [3:0]            midi_cmd_q, midi_ch_q;
  logic [6:0]            midi_d1_q, midi_d2_q;
  logic                  sx_valid_q, sx_pend_q, sx_last_q;
  logic [7:0]            sx_data_q;
  logic [DROP_CNT_W-1:0] drop_q;

  logic       pop, replay, proc;
  logic [7:0] byte_in;
  logic       is_data, is_rt, is_chan, is_f0, is_f7;
  logic       midi_emit, sx_emit, sx_last;
  logic [6:0] emit_d1, emit_d2;
  logic [7:0] sx_byte;
  logic [1:0] drop_n;

  // Only one result can be outstanding per channel, so popping stops while
  // anything is presented or waiting for busy to fall.
  assign pop = run_q & ~bus.fifo_empty & ~bus.fifo_rd_rst_busy &
               ~midi_valid_q & ~midi_pend_q & ~sx_valid_q & ~sx_pend_q &
               (state_q != S_EX_END);
  // The status byte that terminated a sysex is re-processed once the
  // synthesized 0xF7 has been taken, without another pop.
  assign replay = run_q & ~bus.fifo_rd_rst_busy & (state_q == S_EX_END) &
                  ~sx_valid_q & ~sx_pend_q;
  assign proc      = pop | replay;
  assign byte_in   = replay ? hold_q : bus.fifo_out;
  assign eff_state = (state_q == S_EX_END) ? S_IDLE : state_q;

  assign is_data = ~byte_in[7];
  assign is_rt   = &byte_in[7:3];
  assign is_chan = byte_in[7] & (byte_in[7:4] != 4'hF);
  assign is_f0   = (byte_in == 8'hF0);
  assign is_f7   = (byte_in == 8'hF7);

  function automatic logic two_data(input logic [3:0] cmd);
    return !((cmd == 4'hC) || (cmd == 4'hD));
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] c,
                                                    input logic [1:0] n);
    logic [DROP_CNT_W:0] s;
    s = {1'b0, c} + (DROP_CNT_W+1)'(n);
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

  // Decode one byte (popped or replayed) into next-state and emit requests
  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_cmd_d   = rs_cmd_q;
    rs_ch_d    = rs_ch_q;
    d1_d       = d1_q;
    hold_d     = hold_q;
    midi_emit  = 1'b0;
    emit_d1    = d1_q;
    emit_d2    = 7'd0;
    sx_emit    = 1'b0;
    sx_byte    = 8'hF7;
    sx_last    = 1'b0;
    drop_n     = 2'd0;
    if (proc) begin
      if (is_rt) begin
        drop_n = 2'd1;
      end else if (eff_state == S_EX) begin
        sx_emit = 1'b1;
        if (is_data) begin
          sx_byte = byte_in;
        end else begin
          sx_last = 1'b1;
          hold_d  = byte_in;
          state_d = is_f7 ? S_IDLE : S_EX_END;
        end
      end else if (is_data) begin
        if (eff_state == S_D2) begin
          midi_emit = 1'b1;
          emit_d2   = byte_in[6:0];
          state_d   = S_IDLE;
        end else if (rs_valid_q) begin
          if (two_data(rs_cmd_q)) begin
            d1_d    = byte_in[6:0];
            state_d = S_D2;
          end else begin
            midi_emit = 1'b1;
            emit_d1   = byte_in[6:0];
            state_d   = S_IDLE;
          end
        end else begin
          drop_n = 2'd1;
        end
      end else begin
        // A status byte abandons any first data byte already collected
        drop_n = (eff_state == S_D2) ? 2'd1 : 2'd0;
        if (is_chan) begin
          rs_valid_d = 1'b1;
          rs_cmd_d   = byte_in[7:4];
          rs_ch_d    = byte_in[3:0];
          state_d    = S_D1;
        end else if (is_f0) begin
          rs_valid_d = 1'b0;
          state_d    = S_EX;
          sx_emit    = 1'b1;
          sx_byte    = 8'hF0;
        end else begin
          drop_n  = drop_n + 2'd1;
          state_d = S_IDLE;
          if (!is_f7) rs_valid_d = 1'b0;
        end
      end
    end
  end

  // Parser state, output registers and consumer handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      run_q        <= 1'b0;
      rs_valid_q   <= 1'b0;
      rs_cmd_q     <= 4'd0;
      rs_ch_q      <= 4'd0;
      d1_q         <= 7'd0;
      hold_q       <= 8'd0;
      midi_valid_q <= 1'b0;
      midi_pend_q  <= 1'b0;
      midi_cmd_q   <= 4'd0;
      midi_ch_q    <= 4'd0;
      midi_d1_q    <= 7'd0;
      midi_d2_q    <= 7'd0;
      sx_valid_q   <= 1'b0;
      sx_pend_q    <= 1'b0;
      sx_last_q    <= 1'b0;
      sx_data_q    <= 8'd0;
      drop_q       <= '0;
    end else begin
      run_q <= 1'b1;
      if (midi_valid_q && bus.midi_rd) midi_valid_q <= 1'b0;
      if (midi_pend_q && !bus.midi_busy) begin
        midi_valid_q <= 1'b1;
        midi_pend_q  <= 1'b0;
      end
      if (sx_valid_q && bus.sysex_rd) sx_valid_q <= 1'b0;
      if (sx_pend_q && !bus.sysex_busy) begin
        sx_valid_q <= 1'b1;
        sx_pend_q  <= 1'b0;
      end
      if (bus.fifo_rd_rst_busy) begin
        state_q      <= S_IDLE;
        rs_valid_q   <= 1'b0;
        midi_valid_q <= 1'b0;
        midi_pend_q  <= 1'b0;
        sx_valid_q   <= 1'b0;
        sx_pend_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        rs_valid_q <= rs_valid_d;
        rs_cmd_q   <= rs_cmd_d;
        rs_ch_q    <= rs_ch_d;
        d1_q       <= d1_d;
        hold_q     <= hold_d;
        if (midi_emit) begin
          midi_cmd_q <= rs_cmd_q;
          midi_ch_q  <= rs_ch_q;
          midi_d1_q  <= emit_d1;
          midi_d2_q  <= emit_d2;
          if (bus.midi_busy) midi_pend_q  <= 1'b1;
          else               midi_valid_q <= 1'b1;
        end
        if (sx_emit) begin
          sx_data_q <= sx_byte;
          sx_last_q <= sx_last;
          if (bus.sysex_busy) sx_pend_q  <= 1'b1;
          else                sx_valid_q <= 1'b1;
        end
      end
      drop_q <= sat_add(drop_q, drop_n);
    end
  end

  assign bus.fifo_rd     = pop;
  assign bus.midi_valid  = midi_valid_q;
  assign bus.midi_cmd    = midi_cmd_q;
  assign bus.midi_ch     = midi_ch_q;
  assign bus.midi_data1  = midi_d1_q;
  assign bus.midi_data2  = midi_d2_q;
  assign bus.sysex_valid = sx_valid_q;
  assign bus.sysex_data  = sx_data_q;
  assign bus.sysex_last  = sx_last_q;
  assign drop_cnt        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_byte_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_midi_byte_parser
// Description : Scoreboard bench for midi_byte_parser with a byte-stream
//               reference model, directed vectors and random traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_midi_byte_parser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  midi_byte_parser_if bus ();
  midi_byte_parser_if bus1 ();
  logic [7:0] drop8;
  logic       drop1;

  midi_byte_parser #(.DROP_CNT_W(8)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus),  .drop_cnt(drop8));
  midi_byte_parser #(.DROP_CNT_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .drop_cnt(drop1));

  // Narrow-counter instance sees identical traffic
  assign bus1.fifo_out         = bus.fifo_out;
  assign bus1.fifo_empty       = bus.fifo_empty;
  assign bus1.fifo_rd_rst_busy = bus.fifo_rd_rst_busy;
  assign bus1.midi_rd          = bus.midi_rd;
  assign bus1.midi_busy        = bus.midi_busy;
  assign bus1.sysex_rd         = bus.sysex_rd;
  assign bus1.sysex_busy       = bus.sysex_busy;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  fifo_q[$];
  logic        pop_flag = 1'b0;
  logic [7:0]  pop_b;
  logic [21:0] exp_midi[$];
  logic [8:0]  exp_sx[$];
  logic        dir_phase = 1'b1;
  logic        prev_mv = 1'b0, prev_sv = 1'b0, busy_last_m = 1'b0, busy_last_s = 1'b0;
  logic        mrd, srd, mb, sb;
  logic [21:0] e_m;
  logic [8:0]  e_s;

  // Reference model state: running status, collected data bytes, sysex flag
  logic        m_rs_valid;
  logic [3:0]  m_rs_cmd, m_rs_ch;
  logic [6:0]  m_pend[$];
  logic        m_in_sx;
  int          m_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input bit clr_drops);
    m_rs_valid = 1'b0;
    m_in_sx    = 1'b0;
    m_pend.delete();
    exp_midi.delete();
    exp_sx.delete();
    if (clr_drops) m_drops = 0;
  endtask

  function automatic int msg_len(input logic [3:0] cmd);
    return (cmd == 4'hC || cmd == 4'hD) ? 1 : 2;
  endfunction

  task automatic ref_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
      m_drops++;
      return;
    end
    if (m_in_sx) begin
      if (b < 8'h80) begin
        exp_sx.push_back({1'b0, b});
        return;
      end
      exp_sx.push_back({1'b1, 8'hF7});
      m_in_sx = 1'b0;
      if (b == 8'hF7) return;
    end
    if (b < 8'h80) begin
      if (!m_rs_valid) begin
        m_drops++;
        return;
      end
      m_pend.push_back(b[6:0]);
      if (m_pend.size() == msg_len(m_rs_cmd)) begin
        exp_midi.push_back({m_rs_cmd, m_rs_ch, m_pend[0], (m_pend.size() > 1) ? m_pend[1] : 7'd0});
        m_pend.delete();
      end
      return;
    end
    m_drops += m_pend.size();
    m_pend.delete();
    if (b < 8'hF0) begin
      m_rs_valid = 1'b1;
      m_rs_cmd   = b[7:4];
      m_rs_ch    = b[3:0];
    end else if (b == 8'hF0) begin
      m_rs_valid = 1'b0;
      m_in_sx    = 1'b1;
      exp_sx.push_back({1'b0, 8'hF0});
    end else begin
      if (b != 8'hF7) m_rs_valid = 1'b0;
      m_drops++;
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 99);
    if (r < 6)  return 8'hF8 + 8'($urandom_range(0, 7));
    if (r < 10) return 8'hF0;
    if (r < 13) return 8'hF7;
    if (r < 15) return 8'hF1 + 8'($urandom_range(0, 5));
    if (r < 35) return 8'h80 + 8'($urandom_range(0, 111));
    return 8'($urandom_range(0, 127));
  endfunction

  // FWFT FIFO model: retire the byte popped at the last edge, then present
  always @(negedge clk) begin
    if (pop_flag && fifo_q.size() > 0) begin
      pop_b = fifo_q.pop_front();
      ref_byte(pop_b);
    end
    #1;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_out   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    #1;
    pop_flag = bus.fifo_rd;
    if (bus.fifo_rd)
      check("fifo_rd_gate", {28'd0, bus.midi_valid, bus.sysex_valid, bus.fifo_empty, bus.fifo_rd_rst_busy}, 32'd0);
  end

  // Consumer and scoreboard monitor
  always @(negedge clk) begin
    mb  = dir_phase ? 1'b0 : ($urandom_range(0, 3) == 0);
    sb  = dir_phase ? 1'b0 : ($urandom_range(0, 3) == 0);
    mrd = ($urandom_range(0, 2) != 0);
    srd = ($urandom_range(0, 2) != 0);
    if (rst_n) begin
      if (bus.midi_valid && !prev_mv) begin
        check("midi_rise_busy", {31'd0, busy_last_m}, 32'd0);
        if (dir_phase) check("midi_latency", {31'd0, pop_flag}, 32'd1);
      end
      if (bus.sysex_valid && !prev_sv)
        check("sysex_rise_busy", {31'd0, busy_last_s}, 32'd0);
      if (bus.midi_valid && mrd) begin
        if (exp_midi.size() == 0) begin
          total++; bad++;
          $display("FAIL midi_extra: got %0h%0h %0h %0h expected none",
                   bus.midi_cmd, bus.midi_ch, bus.midi_data1, bus.midi_data2);
        end else begin
          e_m = exp_midi.pop_front();
          check("midi_msg", {10'd0, bus.midi_cmd, bus.midi_ch, bus.midi_data1, bus.midi_data2}, {10'd0, e_m});
        end
      end
      if (bus.sysex_valid && srd) begin
        if (exp_sx.size() == 0) begin
          total++; bad++;
          $display("FAIL sysex_extra: got %0h last %0b expected none", bus.sysex_data, bus.sysex_last);
        end else begin
          e_s = exp_sx.pop_front();
          check("sysex_byte", {23'd0, bus.sysex_last, bus.sysex_data}, {23'd0, e_s});
        end
      end
    end
    prev_mv        = bus.midi_valid;
    prev_sv        = bus.sysex_valid;
    busy_last_m    = mb;
    busy_last_s    = sb;
    bus.midi_rd    = mrd;
    bus.midi_busy  = mb;
    bus.sysex_rd   = srd;
    bus.sysex_busy = sb;
  end

  task automatic drain(input string tag);
    int quiet = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #3;
      if (fifo_q.size() == 0 && !pop_flag && exp_midi.size() == 0 && exp_sx.size() == 0 &&
          !bus.midi_valid && !bus.sysex_valid) quiet++;
      else quiet = 0;
      if (quiet == 4) return;
    end
    total++; bad++;
    $display("FAIL drain_%s: got fifo=%0d midi_q=%0d sysex_q=%0d expected all empty",
             tag, fifo_q.size(), exp_midi.size(), exp_sx.size());
  endtask

  task automatic check_drops(input string tag);
    check({"drop8_", tag}, {24'd0, drop8}, (m_drops > 255) ? 32'd255 : 32'(m_drops));
    check({"drop1_", tag}, {31'd0, drop1}, (m_drops > 0) ? 32'd1 : 32'd0);
  endtask

  logic [7:0] dir_bytes [17] = '{8'h90, 8'h3C, 8'h64,
                                 8'h91, 8'h3C, 8'h64, 8'h3E, 8'h00,
                                 8'hC5, 8'hF8, 8'h07,
                                 8'hF0, 8'h7E, 8'h01, 8'h80, 8'h40, 8'h00};
  int dir_ends  [4] = '{3, 8, 11, 17};
  int spec_drop [4] = '{0, 0, 1, 1};

  initial begin
    int idx;
    rst_n = 1'b0;
    bus.fifo_rd_rst_busy = 1'b0;
    model_reset(1'b1);
    repeat (3) @(negedge clk);
    #3;
    check("rst_fifo_rd", {31'd0, bus.fifo_rd}, 32'd0);
    check("rst_outs", {bus.midi_valid, bus.sysex_valid, bus.sysex_last}, 3'd0);
    check("rst_data", {bus.midi_cmd, bus.midi_ch, bus.midi_data1, bus.midi_data2, bus.sysex_data}, 30'd0);
    check("rst_drop", {drop8, drop1}, 9'd0);
    rst_n = 1'b1;

    // Directed vectors
    idx = 0;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      while (idx < dir_ends[g]) begin
        fifo_q.push_back(dir_bytes[idx]);
        idx++;
      end
      drain($sformatf("dir%0d", g));
      check_drops($sformatf("dir%0d", g));
      check($sformatf("drop_vec%0d", g), {24'd0, drop8}, 32'(spec_drop[g]));
    end

    // Reset in the middle of a message
    @(negedge clk);
    fifo_q.push_back(8'h90);
    fifo_q.push_back(8'h3C);
    drain("pre_reset");
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    model_reset(1'b1);
    #1;
    check("rst_mid_outs", {bus.midi_valid, bus.sysex_valid, bus.sysex_last, bus.fifo_rd}, 4'd0);
    check("rst_mid_drop", {drop8, drop1}, 9'd0);
    fifo_q.push_back(8'h64);
    repeat (2) @(negedge clk);
    #3;
    check("rst_hold_fifo_rd", {bus.fifo_empty, bus.fifo_rd}, 2'b00);
    rst_n = 1'b1;
    drain("post_reset");
    check_drops("post_reset");
    @(negedge clk);
    fifo_q.push_back(8'h40);
    fifo_q.push_back(8'hF3);
    fifo_q.push_back(8'h40);
    drain("sat");
    check_drops("sat");
    check("drop1_sat", {31'd0, drop1}, 32'd1);

    // FIFO read-reset busy clears running status and partial data
    @(negedge clk);
    fifo_q.push_back(8'h91);
    fifo_q.push_back(8'h3C);
    drain("pre_rrb");
    @(negedge clk);
    #3;
    bus.fifo_rd_rst_busy = 1'b1;
    @(negedge clk);
    #3;
    bus.fifo_rd_rst_busy = 1'b0;
    model_reset(1'b0);
    fifo_q.push_back(8'h40);
    drain("rrb");
    check_drops("rrb");

    // Random traffic with random consumer busy/read behaviour
    dir_phase = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if (fifo_q.size() < 12) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) fifo_q.push_back(rand_byte());
      end
    end
    drain("random");
    check_drops("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
